// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, main-control state encoding,
// ALU-op and datapath select codes, and the control word bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  // Shared with the ALU control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] opALU;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic isLegalOp(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Combinational state-to-control decode for the multicycle main control.
// Only FETCH's IR/PC writes and DECODE's illegal flag look at inputs.
module main_control_decode
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic        memReady,
  input  logic [5:0]  opcode,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.opALU    = ALUOP_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.irWrite  = memReady;
        ctrl.pcWrite  = memReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB   = SRCB_IMMSH;
        ctrl.opALU     = ALUOP_ADD;
        ctrl.illegalOp = !isLegalOp(opcode);
      end
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.opALU   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      S_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.opALU   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_B;
        ctrl.opALU       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: state register and next-state logic;
// output decode lives in main_control_decode.
module mips_main_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] OpALU,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t stateQ, stateNext;
  ctrl_t  ctrl;

  always_comb begin
    stateNext = S_START;
    case (stateQ)
      S_START:  stateNext = S_FETCH;
      S_FETCH:  stateNext = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_RTYPE:     stateNext = S_EXEC;
          OP_BEQ:       stateNext = S_BRANCH;
          OP_J:         stateNext = S_JUMP;
          default:      stateNext = S_FETCH;
        endcase
      end
      S_MEMADR: stateNext = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  stateNext = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  stateNext = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   stateNext = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: stateNext = S_FETCH;
      default:  stateNext = S_START;  // unused encodings recover via START
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stateQ <= S_START;
    else          stateQ <= stateNext;
  end

  main_control_decode uDecode (
    .state    (stateQ),
    .memReady (mem_ready),
    .opcode   (opcode),
    .ctrl     (ctrl)
  );

  assign OpALU       = ctrl.opALU;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign PCSource    = ctrl.pcSource;
  assign PCWrite     = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign MemtoReg    = ctrl.memtoReg;
  assign IRWrite     = ctrl.irWrite;
  assign RegWrite    = ctrl.regWrite;
  assign RegDst      = ctrl.regDst;
  assign illegal_op  = ctrl.illegalOp;
  assign state       = stateQ;

endmodule

// File: tb/tb_mips_main_control.sv
// Randomized instruction stream against an instruction-level model that
// expands each opcode and its wait counts into the expected cycle sequence.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] OpALU, ALUSrcB, PCSource;
  logic       ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, RegWrite, RegDst, illegal_op;
  logic [3:0] state;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  mips_main_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .OpALU(OpALU), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .illegal_op(illegal_op), .state(state)
  );

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  logic [5:0] legalOps [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};

  function automatic bit legal(input logic [5:0] op);
    foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] obsVec();
    return {OpALU, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
            MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, illegal_op};
  endfunction

  // Expected control word from the per-state output list
  function automatic logic [16:0] expVec(input int st, input logic mr, input logic [5:0] op);
    logic [1:0] aluOp = 0, srcB = 0, pcSrc = 0;
    logic srcA = 0, pcW = 0, pcWC = 0, iod = 0, mRd = 0, mWr = 0;
    logic m2r = 0, irW = 0, rW = 0, rD = 0, ill = 0;
    case (st)
      1:  begin mRd = 1; srcB = 2'b01; irW = mr; pcW = mr; end
      2:  begin srcB = 2'b11; ill = !legal(op); end
      3:  begin srcA = 1; srcB = 2'b10; end
      4:  begin mRd = 1; iod = 1; end
      5:  begin rW = 1; m2r = 1; end
      6:  begin mWr = 1; iod = 1; end
      7:  begin srcA = 1; aluOp = 2'b10; end
      8:  begin rW = 1; rD = 1; end
      9:  begin srcA = 1; aluOp = 2'b01; pcWC = 1; pcSrc = 2'b01; end
      10: begin pcW = 1; pcSrc = 2'b10; end
      default: ;
    endcase
    return {aluOp, srcA, srcB, pcSrc, pcW, pcWC, iod, mRd, mWr, m2r, irW, rW, rD, ill};
  endfunction

  // Expected cycle sequence for one instruction; wait cycles carry mr=0
  function automatic void buildSeq(input logic [5:0] op, input int fw, input int mw,
                                   output step_t q[$]);
    q = {};
    repeat (fw) q.push_back('{1, 1'b0});
    q.push_back('{1, 1'b1});
    q.push_back('{2, 1'($urandom)});
    case (op)
      6'b100011: begin
        q.push_back('{3, 1'($urandom)});
        repeat (mw) q.push_back('{4, 1'b0});
        q.push_back('{4, 1'b1});
        q.push_back('{5, 1'($urandom)});
      end
      6'b101011: begin
        q.push_back('{3, 1'($urandom)});
        repeat (mw) q.push_back('{6, 1'b0});
        q.push_back('{6, 1'b1});
      end
      6'b000000: begin
        q.push_back('{7, 1'($urandom)});
        q.push_back('{8, 1'($urandom)});
      end
      6'b000100: q.push_back('{9, 1'($urandom)});
      6'b000010: q.push_back('{10, 1'($urandom)});
      default: ;
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT in FETCH
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
    step_t q[$];
    int pcwCnt = 0, irwCnt = 0, illCnt = 0, rwCnt = 0;
    int expPcw, expRw;
    buildSeq(op, fw, mw, q);
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      opcode = op;
      @(negedge clk);
      check($sformatf("state op=%b step%0d", op, i), 32'(state), 32'(q[i].st));
      check($sformatf("ctrl op=%b st=%0d", op, q[i].st), 32'(obsVec()),
            32'(expVec(q[i].st, q[i].mr, op)));
      pcwCnt += int'(PCWrite);
      irwCnt += int'(IRWrite);
      illCnt += int'(illegal_op);
      rwCnt  += int'(RegWrite);
      @(posedge clk); #1;
    end
    expPcw = (op == 6'b000010) ? 2 : 1;
    expRw  = (op == 6'b000000 || op == 6'b100011) ? 1 : 0;
    check($sformatf("pcWrite count op=%b", op), 32'(pcwCnt), 32'(expPcw));
    check($sformatf("irWrite count op=%b", op), 32'(irwCnt), 32'd1);
    check($sformatf("illegal count op=%b", op), 32'(illCnt), 32'(legal(op) ? 0 : 1));
    check($sformatf("regWrite count op=%b", op), 32'(rwCnt), 32'(expRw));
  endtask

  initial begin
    logic [5:0] op;
    reset_n = 1'b0;
    opcode = '0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl", 32'(obsVec()), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("start after release", 32'(state), 32'd0);
    @(posedge clk); #1;

    // Directed cases from the plan
    runInstr(6'b000000, 0, 0);
    runInstr(6'b100011, 2, 3);
    runInstr(6'b101011, 0, 2);
    runInstr(6'b000100, 0, 0);
    runInstr(6'b000010, 0, 0);
    runInstr(6'b111111, 0, 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = legalOps[$urandom_range(0, 4)];
      end
      runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset mid-MEMWR while waiting on memory
    opcode = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr before reset", 32'(state), 32'd6);
    check("memWrite before reset", 32'(MemWrite), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset ctrl", 32'(obsVec()), 32'd0);
    @(posedge clk); #1;
    check("held reset state", 32'(state), 32'd0);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("start after mid reset", 32'(state), 32'd0);
    check("start ctrl", 32'(obsVec()), 32'd0);
    @(posedge clk); #1;
    runInstr(6'b100011, 1, 1);
    runInstr(6'b000000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
